exec_sequencer: RTL and testbench

//  Sequences the single-cycle datapath: generates pc_en_in and a commit strobe that the top

---
 rtl/exec_sequencer.sv | 156 +++++++++++++++
 tb/tb_exec_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Sequences the single-cycle datapath: gates PC advance/commit, stalls loads and serial
// accesses, provides run/halt/single-step control and cycle/retire counters.
module exec_sequencer #(
  parameter int LOAD_WAIT = 1,
  parameter int BOOT_HOLD = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_in,
  input  logic             halt_req_in,
  input  logic             step_in,
  input  logic             is_load_in,
  input  logic             serial_rd_in,
  input  logic             serial_wr_in,
  input  logic             serial_valid_in,
  input  logic             serial_ready_in,
  output logic             pc_en_out,
  output logic             commit_out,
  output logic             halted_out,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] cycle_count_out,
  output logic [CNT_W-1:0] retire_count_out
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_RUN   = 3'd1,
    S_LWAIT = 3'd2,
    S_SWAIT = 3'd3,
    S_HALT  = 3'd4,
    S_STEP  = 3'd5
  } state_e;

  localparam int WW = $clog2(LOAD_WAIT + 2);
  localparam int BW = $clog2(BOOT_HOLD + 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             halt_pend_q, halt_pend_d;
  logic             step_mode_q, step_mode_d;
  logic             halted_q;
  logic             run_q;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             commit;

  logic serial_stall;
  logic load_stall;
  logic stop_req;
  logic exit_halt;

  // A serial load waits only on the handshake, never on the RAM load delay.
  assign serial_stall = (serial_rd_in & ~serial_valid_in) | (serial_wr_in & ~serial_ready_in);
  assign load_stall   = is_load_in & ~serial_rd_in & (LOAD_WAIT > 0);
  assign stop_req     = halt_req_in | halt_pend_q | ~run_in;
  assign exit_halt    = halt_req_in | halt_pend_q | step_mode_q | ~run_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= BW'(BOOT_HOLD);
      wait_cnt_q  <= '0;
      halt_pend_q <= 1'b0;
      step_mode_q <= 1'b0;
      halted_q    <= 1'b0;
      run_q       <= 1'b0;
      cycle_q     <= '0;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      halt_pend_q <= halt_pend_d;
      step_mode_q <= step_mode_d;
      halted_q    <= (state_d == S_HALT);
      run_q       <= run_in;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    step_mode_d = step_mode_q;
    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BW'(1)) state_d = run_in ? S_RUN : S_HALT;
        else                      boot_cnt_d = boot_cnt_q - BW'(1);
      end
      S_RUN, S_STEP: begin
        if (state_q == S_RUN && stop_req) begin
          state_d = S_HALT;
        end else if (serial_stall) begin
          state_d     = S_SWAIT;
          step_mode_d = step_mode_q | (state_q == S_STEP);
        end else if (load_stall) begin
          state_d     = S_LWAIT;
          wait_cnt_d  = WW'(LOAD_WAIT);
          step_mode_d = step_mode_q | (state_q == S_STEP);
        end else if (state_q == S_STEP) begin
          state_d = S_HALT;
        end
      end
      S_LWAIT: begin
        wait_cnt_d = wait_cnt_q - WW'(1);
        if (commit) begin
          state_d     = exit_halt ? S_HALT : S_RUN;
          step_mode_d = 1'b0;
        end
      end
      S_SWAIT: begin
        if (commit) begin
          state_d     = exit_halt ? S_HALT : S_RUN;
          step_mode_d = 1'b0;
        end
      end
      S_HALT: begin
        if (step_in)              state_d = S_STEP;
        else if (run_in & ~run_q) state_d = S_RUN;
      end
      default: state_d = S_HALT;
    endcase

    halt_pend_d = halt_pend_q;
    if (state_d == S_HALT && state_q != S_HALT)
      halt_pend_d = 1'b0;
    else if (halt_req_in && state_q != S_BOOT && state_q != S_HALT)
      halt_pend_d = 1'b1;

    cycle_d  = (state_q != S_BOOT && state_q != S_HALT) ? cycle_q + CNT_W'(1) : cycle_q;
    retire_d = commit ? retire_q + CNT_W'(1) : retire_q;
  end

  always_comb begin
    commit = 1'b0;
    case (state_q)
      S_RUN:   commit = ~stop_req & ~serial_stall & ~load_stall;
      S_STEP:  commit = ~serial_stall & ~load_stall;
      S_LWAIT: commit = (wait_cnt_q == WW'(1));
      S_SWAIT: commit = ~serial_stall;
      default: commit = 1'b0;
    endcase
  end

  assign commit_out       = commit;
  assign pc_en_out        = commit;
  assign halted_out       = halted_q;
  assign state_out        = state_q;
  assign cycle_count_out  = cycle_q;
  assign retire_count_out = retire_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: per-cycle vector table plus a retire-count scoreboard.
module tb_exec_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       run_in, halt_req_in, step_in, is_load_in;
  logic       serial_rd_in, serial_wr_in, serial_valid_in, serial_ready_in;
  logic       pc_en_out, commit_out, halted_out;
  logic [2:0] state_out;
  logic [3:0] cycle_count_out, retire_count_out;

  exec_sequencer #(.LOAD_WAIT(1), .BOOT_HOLD(2), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .run_in(run_in), .halt_req_in(halt_req_in), .step_in(step_in), .is_load_in(is_load_in),
    .serial_rd_in(serial_rd_in), .serial_wr_in(serial_wr_in),
    .serial_valid_in(serial_valid_in), .serial_ready_in(serial_ready_in),
    .pc_en_out(pc_en_out), .commit_out(commit_out), .halted_out(halted_out),
    .state_out(state_out), .cycle_count_out(cycle_count_out),
    .retire_count_out(retire_count_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       run, hreq, step, ld, srd, swr, sv, sr;
    logic       ecommit;
    logic [2:0] estate;
    logic [3:0] ecyc;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb_q[$];
  logic [3:0] exp_ret;
  int         checks = 0;
  int         failures = 0;

  function automatic vec_t mk(input logic run, hreq, step, ld, srd, swr, sv, sr, ec,
                              input logic [2:0] es, input logic [3:0] ecyc);
    vec_t v;
    v.run = run; v.hreq = hreq; v.step = step; v.ld = ld;
    v.srd = srd; v.swr = swr; v.sv = sv; v.sr = sr;
    v.ecommit = ec; v.estate = es; v.ecyc = ecyc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic run_row(input vec_t v, input int idx);
    logic       dut_commit;
    logic [3:0] e;
    run_in = v.run; halt_req_in = v.hreq; step_in = v.step; is_load_in = v.ld;
    serial_rd_in = v.srd; serial_wr_in = v.swr;
    serial_valid_in = v.sv; serial_ready_in = v.sr;
    if (v.ecommit) begin
      exp_ret = exp_ret + 4'd1;
      sb_q.push_back(exp_ret);
    end
    @(negedge clock);
    chk($sformatf("commit[%0d]", idx), commit_out, v.ecommit);
    chk($sformatf("pc_en[%0d]", idx), pc_en_out, v.ecommit);
    chk($sformatf("state[%0d]", idx), state_out, v.estate);
    chk($sformatf("halted[%0d]", idx), halted_out, (v.estate == 3'd4));
    chk($sformatf("cycle[%0d]", idx), cycle_count_out, v.ecyc);
    dut_commit = commit_out;
    @(posedge clock);
    #1;
    if (dut_commit) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL retire[%0d]: got commit, required no commit", idx);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("retire[%0d]", idx), retire_count_out, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    run_in = 1'b1; halt_req_in = 1'b0; step_in = 1'b0; is_load_in = 1'b0;
    serial_rd_in = 1'b0; serial_wr_in = 1'b0; serial_valid_in = 1'b0; serial_ready_in = 1'b0;
    exp_ret = 4'd0;

    // run hreq step ld srd swr sv sr | commit state cycle
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd0,4'd0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd0,4'd0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,3'd1,4'(i)));
    vecs.push_back(mk(1,0,0,1,0,0,0,0, 0,3'd1,4'd8));   // load -> LWAIT
    vecs.push_back(mk(1,0,0,1,0,0,0,0, 1,3'd2,4'd9));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,3'd1,4'd10));
    vecs.push_back(mk(1,0,0,1,1,0,0,0, 0,3'd1,4'd11));  // serial load stalls
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,1,1,0,0,0, 0,3'd3,4'(12+i)));
    vecs.push_back(mk(1,0,0,1,1,0,1,0, 1,3'd3,4'd0));   // cycle counter wraps
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,3'd1,4'd1));
    vecs.push_back(mk(1,0,0,0,1,0,0,0, 0,3'd1,4'd2));
    vecs.push_back(mk(1,1,0,0,1,0,0,0, 0,3'd3,4'd3));   // halt during SWAIT
    vecs.push_back(mk(1,0,0,0,1,0,0,0, 0,3'd3,4'd4));
    vecs.push_back(mk(1,0,0,0,1,0,1,0, 1,3'd3,4'd5));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd6));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd6));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 0,3'd4,4'd6));   // step a load
    vecs.push_back(mk(1,0,0,1,0,0,0,0, 0,3'd5,4'd6));
    vecs.push_back(mk(1,0,0,1,0,0,0,0, 1,3'd2,4'd7));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd8));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd8));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,3'd4,4'd8));   // run edge resumes
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd8));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,3'd1,4'd8));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,3'd1,4'd9));   // retire wraps to 0
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,3'd1,4'd10));
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,3'd1,4'd11));  // halt in RUN
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd12));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 0,3'd4,4'd12));  // plain step
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,3'd5,4'd12));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd13));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,3'd4,4'd13));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd13));
    vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,3'd1,4'd13));  // serial store stall
    vecs.push_back(mk(1,0,0,0,0,1,0,1, 1,3'd3,4'd14));
    vecs.push_back(mk(1,0,0,1,1,0,1,0, 1,3'd1,4'd15));  // ready serial load: no LWAIT
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,3'd1,4'd0));   // run low halts
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,3'd4,4'd1));

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_commit", commit_out, 0);
    chk("rst_pc_en", pc_en_out, 0);
    chk("rst_state", state_out, 0);
    chk("rst_halted", halted_out, 0);
    chk("rst_cycle", cycle_count_out, 0);
    chk("rst_retire", retire_count_out, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

    // Reset asserted in the middle of a load's commit cycle.
    run_row(mk(1,0,0,0,0,0,0,0, 0,3'd4,4'd1), 100);
    run_row(mk(1,0,0,1,0,0,0,0, 0,3'd1,4'd1), 101);
    chk("lw_state", state_out, 3'd2);
    chk("lw_commit", commit_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_commit", commit_out, 0);
    chk("arst_pc_en", pc_en_out, 0);
    chk("arst_state", state_out, 0);
    chk("arst_halted", halted_out, 0);
    chk("arst_cycle", cycle_count_out, 0);
    chk("arst_retire", retire_count_out, 0);
    @(posedge clock);
    #1;
    chk("arst_hold_commit", commit_out, 0);
    reset = 1'b0;
    exp_ret = 4'd0;
    run_row(mk(1,0,0,0,0,0,0,0, 0,3'd0,4'd0), 200);
    run_row(mk(1,0,0,0,0,0,0,0, 0,3'd0,4'd0), 201);
    run_row(mk(1,0,0,0,0,0,0,0, 1,3'd1,4'd0), 202);
    run_row(mk(1,0,0,0,0,0,0,0, 1,3'd1,4'd1), 203);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
